// File: rtl/uart_rx.sv
// uart_rx -- 8-bit UART receiver, 8N1 (or 8E1 with UART_RX_PARITY_EN defined).
//
// Parameters
//   CLKS_PER_BIT  system clocks per UART bit (4..65535)
// Ports
//   clk              system clock, rising edge
//   rst              synchronous active-high reset
//   i_RX_Serial      asynchronous serial line, idle high
//   o_RX_DV          one-cycle pulse, o_RX_Byte valid
//   o_RX_Byte        last good byte, held until next o_RX_DV
//   o_RX_Active      high from start-bit detection until back in IDLE
//   o_RX_Frame_Err   one-cycle pulse when the stop bit samples low
//   o_RX_Parity_Err  one-cycle pulse on even-parity mismatch (0 unless
//                    UART_RX_PARITY_EN is defined)
module uart_rx #(
  parameter int CLKS_PER_BIT = 434
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       i_RX_Serial,
  output logic       o_RX_DV,
  output logic [7:0] o_RX_Byte,
  output logic       o_RX_Active,
  output logic       o_RX_Frame_Err,
  output logic       o_RX_Parity_Err
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] CNT_MAX  = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] CNT_HALF = CW'((CLKS_PER_BIT - 1) / 2);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, CLEANUP} state_t;

  state_t          state, state_nxt;
  logic            rx_meta, rx_sync;
  logic [1:0]      sync_vld;   // shift register: rx_sync carries real line data once [1] is set
  logic            armed;      // a high line has been seen since reset
  logic [CW-1:0]   clk_cnt;
  logic [2:0]      bit_idx;
  logic [7:0]      rx_shift;
  logic            cnt_clr, data_smp, stop_smp;
`ifdef UART_RX_PARITY_EN
  logic            par_smp, par_bad;
`endif

  // state register
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // next state
  always_comb begin
    state_nxt = state;
    case (state)
      // armed keeps a line that is already low at reset release from
      // looking like a start bit; only a fresh falling edge starts a frame.
      IDLE:    if (armed && !rx_sync) state_nxt = START;
      START:   if (clk_cnt == CNT_HALF) state_nxt = rx_sync ? IDLE : DATA;
      DATA:    if (clk_cnt == CNT_MAX && bit_idx == 3'd7)
`ifdef UART_RX_PARITY_EN
                 state_nxt = PARITY;
`else
                 state_nxt = STOP;
`endif
      PARITY:  if (clk_cnt == CNT_MAX) state_nxt = STOP;
      STOP:    if (clk_cnt == CNT_MAX) state_nxt = CLEANUP;
      CLEANUP: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // outputs / datapath strobes
  always_comb begin
    o_RX_Active = (state == START) || (state == DATA) ||
                  (state == PARITY) || (state == STOP);
    cnt_clr     = (state == IDLE) || (clk_cnt == CNT_MAX) ||
                  (state == START && clk_cnt == CNT_HALF);
    data_smp    = (state == DATA) && (clk_cnt == CNT_MAX);
    stop_smp    = (state == STOP) && (clk_cnt == CNT_MAX);
`ifdef UART_RX_PARITY_EN
    par_smp     = (state == PARITY) && (clk_cnt == CNT_MAX);
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rx_meta        <= 1'b1;
      rx_sync        <= 1'b1;
      sync_vld       <= '0;
      armed          <= 1'b0;
      clk_cnt        <= '0;
      bit_idx        <= '0;
      rx_shift       <= '0;
      o_RX_Byte      <= '0;
      o_RX_DV        <= 1'b0;
      o_RX_Frame_Err <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_bad         <= 1'b0;
      o_RX_Parity_Err <= 1'b0;
`endif
    end else begin
      rx_meta        <= i_RX_Serial;
      rx_sync        <= rx_meta;
      sync_vld       <= {sync_vld[0], 1'b1};
      armed          <= armed | (sync_vld[1] & rx_sync);
      clk_cnt        <= cnt_clr ? '0 : clk_cnt + 1'b1;
      o_RX_DV        <= 1'b0;
      o_RX_Frame_Err <= 1'b0;
`ifdef UART_RX_PARITY_EN
      o_RX_Parity_Err <= 1'b0;
      if (par_smp) par_bad <= rx_sync ^ (^rx_shift);
`endif
      if (data_smp) begin
        rx_shift <= {rx_sync, rx_shift[7:1]};  // LSB arrives first
        bit_idx  <= bit_idx + 3'd1;            // wraps 7 -> 0 on the last bit
      end
      if (stop_smp) begin
        if (!rx_sync)
          o_RX_Frame_Err <= 1'b1;              // frame error wins over parity
`ifdef UART_RX_PARITY_EN
        else if (par_bad)
          o_RX_Parity_Err <= 1'b1;
`endif
        else begin
          o_RX_Byte <= rx_shift;
          o_RX_DV   <= 1'b1;
        end
      end
    end
  end

`ifndef UART_RX_PARITY_EN
  assign o_RX_Parity_Err = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx -- scoreboard bench for uart_rx at CLKS_PER_BIT=16.
// Stimulus pushes the expected pulse (kind + o_RX_Byte value) into a queue;
// a negedge monitor pops and compares whenever any output pulse appears.
module tb_uart_rx;
  localparam int CPB = 16;

  logic       clk = 1'b0;
  logic       rst;
  logic       rx;
  logic       dv, active, fe, pe;
  logic [7:0] rx_byte;

  uart_rx #(.CLKS_PER_BIT(CPB)) dut (
    .clk(clk), .rst(rst), .i_RX_Serial(rx),
    .o_RX_DV(dv), .o_RX_Byte(rx_byte), .o_RX_Active(active),
    .o_RX_Frame_Err(fe), .o_RX_Parity_Err(pe)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         kind;   // 0 = DV, 1 = frame error, 2 = parity error
    logic [7:0] data;   // o_RX_Byte expected while the pulse is high
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   failures = 0;
  int   cyc = 0;
  int   last_dv_cyc = -1;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  task automatic expect_pulse(input int kind, input logic [7:0] data);
    exp_t e;
    e.kind = kind;
    e.data = data;
    q.push_back(e);
  endtask

  // monitor
  always @(negedge clk) begin
    exp_t e;
    int   k;
    int   n;
    if (!rst && (dv || fe || pe)) begin
      n = int'(dv) + int'(fe) + int'(pe);
      chk("pulse_exclusive", n, 1);
      k = dv ? 0 : (fe ? 1 : 2);
      if (dv) last_dv_cyc = cyc;
      if (q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_pulse: got kind %0d byte %0h expected none (cycle %0d)", k, rx_byte, cyc);
      end else begin
        e = q.pop_front();
        chk("pulse_kind", k, e.kind);
        chk("rx_byte", rx_byte, e.data);
      end
    end
  end

  task automatic idle(input int n);
    rx = 1'b1;
    repeat (n) @(negedge clk);
  endtask

  task automatic send_bit(input logic b);
    rx = b;
    repeat (CPB) @(negedge clk);
  endtask

  // bad_par flips the even-parity bit when parity is built in
  task automatic send_frame(input logic [7:0] d, input logic stop_b, input logic bad_par);
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(d[i]);
`ifdef UART_RX_PARITY_EN
    send_bit((^d) ^ bad_par);
`else
    if (bad_par) $display("note: bad_par ignored in 8N1 build");
`endif
    send_bit(stop_b);
  endtask

  initial begin
    int t0;
    rst = 1'b1;
    rx  = 1'b1;
    repeat (3) @(negedge clk);
    chk("reset_dv", dv, 0);
    chk("reset_byte", rx_byte, 8'h00);
    chk("reset_active", active, 0);
    chk("reset_frame_err", fe, 0);
    chk("reset_parity_err", pe, 0);
    rst = 1'b0;
    idle(10);

    // good 8N1 byte, latency from start edge to DV
    expect_pulse(0, 8'hA5);
    t0 = cyc;
    send_frame(8'hA5, 1'b1, 1'b0);
    idle(10);
    chk("a5_latency_ok", (last_dv_cyc - t0 >= 150) && (last_dv_cyc - t0 <= 165), 1);

    // false start: low 5 clocks then high
    rx = 1'b0;
    repeat (5) @(negedge clk);
    chk("false_start_active", active, 1);
    rx = 1'b1;
    repeat (12) @(negedge clk);
    chk("false_start_idle", active, 0);
    idle(10);

    // stop bit forced low: frame error, byte keeps A5
    expect_pulse(1, 8'hA5);
    send_frame(8'h3C, 1'b0, 1'b0);
    idle(40);
    chk("after_frame_err_idle", active, 0);

    // back-to-back frames, no idle gap
    expect_pulse(0, 8'h00);
    expect_pulse(0, 8'hFF);
    send_frame(8'h00, 1'b1, 1'b0);
    send_frame(8'hFF, 1'b1, 1'b0);
    idle(20);

    // reset during D3 of 8'h81 (D0=1, D1..D6=0, D7=1)
    send_bit(1'b0);
    send_bit(1'b1);
    send_bit(1'b0);
    send_bit(1'b0);
    rx = 1'b0;
    repeat (8) @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    chk("midframe_rst_active", active, 0);
    chk("midframe_rst_byte", rx_byte, 8'h00);
    rst = 1'b0;
    repeat (CPB - 8) @(negedge clk);
    send_bit(1'b0);
    send_bit(1'b0);
    send_bit(1'b0);
    send_bit(1'b1);
    send_bit(1'b1);
    idle(20);
    chk("aborted_no_active", active, 0);
    expect_pulse(0, 8'h42);
    send_frame(8'h42, 1'b1, 1'b0);
    idle(20);

`ifdef UART_RX_PARITY_EN
    expect_pulse(2, 8'h42);
    send_frame(8'h07, 1'b1, 1'b1);
    idle(20);
    expect_pulse(0, 8'h07);
    send_frame(8'h07, 1'b1, 1'b0);
    idle(20);
`endif

    for (int i = 0; i < 400 && q.size() != 0; i++) @(negedge clk);
    chk("scoreboard_drained", q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
